// File: rtl/timer_cmp_if.sv
// Data-bus port bundle for timer_cmp: registered-read peripheral bus plus
// the per-channel level interrupts.
interface timer_cmp_if #(
    parameter int N_CMP = 2
);
    logic             sel;
    logic             we;
    logic [31:0]      addr;
    logic [31:0]      din;
    logic [31:0]      dout;
    logic [N_CMP-1:0] irq;

    modport master (output sel, we, addr, din, input dout, irq);
    modport slave  (input sel, we, addr, din, output dout, irq);
endinterface

// File: rtl/timer_cmp.sv
// Memory-mapped system timer: prescaled CNT_W-bit counter, tear-free LO/HI
// reads through a shadow register, and N_CMP level-interrupt compare channels.
module timer_cmp #(
    parameter int CNT_W   = 64,
    parameter int N_CMP   = 2,
    parameter int PRESC_W = 8
) (
    input  logic       clock,
    input  logic       reset,
    timer_cmp_if.slave bus
);
    localparam int HW = CNT_W - 32;

    logic [CNT_W-1:0]            r_count;
    logic [HW-1:0]               r_hi_shadow;
    logic [PRESC_W-1:0]          r_pcnt;
    logic [PRESC_W-1:0]          r_presc;
    logic                        r_en;
    logic [N_CMP-1:0]            r_ie;
    logic [N_CMP-1:0]            r_irq;
    logic [N_CMP-1:0][CNT_W-1:0] r_cmp;
    logic [31:0]                 r_dout;

    logic [4:0]  w_idx;
    logic        w_wr;
    logic        w_rd;
    logic        w_tick;
    logic [31:0] w_rdata;
    logic        w_unused_addr;

    assign w_idx         = bus.addr[6:2];
    assign w_wr          = bus.sel & bus.we;
    assign w_rd          = bus.sel & ~bus.we;
    assign w_tick        = r_en && (r_pcnt == r_presc);
    assign w_unused_addr = ^{bus.addr[31:7], bus.addr[1:0]};

    // A CTRL write restarts the prescaler phase; a tick in that same cycle
    // still lands because it was decided on the old settings.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_en    <= 1'b0;
            r_presc <= '0;
            r_ie    <= '0;
            r_pcnt  <= '0;
        end else if (w_wr && w_idx == 5'd2) begin
            r_en    <= bus.din[0];
            r_presc <= bus.din[8 +: PRESC_W];
            r_ie    <= bus.din[24 +: N_CMP];
            r_pcnt  <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else if (r_en) begin
            r_pcnt <= r_pcnt + PRESC_W'(1);
        end
    end

    // Bus writes to either half beat a coincident tick; that tick is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_wr && w_idx == 5'd0) begin
            r_count[31:0] <= bus.din;
        end else if (w_wr && w_idx == 5'd1) begin
            r_count[CNT_W-1:32] <= bus.din[HW-1:0];
        end else if (w_tick) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cmp <= '1;
        end else if (w_wr) begin
            for (int i = 0; i < N_CMP; i++) begin
                if (w_idx == 5'(4 + 2*i)) r_cmp[i][31:0]       <= bus.din;
                if (w_idx == 5'(5 + 2*i)) r_cmp[i][CNT_W-1:32] <= bus.din[HW-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_irq <= '0;
        end else begin
            for (int i = 0; i < N_CMP; i++)
                r_irq[i] <= r_ie[i] && (r_count >= r_cmp[i]);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            5'd0: w_rdata = r_count[31:0];
            5'd1: w_rdata = 32'(r_hi_shadow);
            5'd2: begin
                w_rdata[0]              = r_en;
                w_rdata[8 +: PRESC_W]   = r_presc;
                w_rdata[24 +: N_CMP]    = r_ie;
            end
            5'd3: w_rdata = 32'(r_irq);
            default: begin
                for (int i = 0; i < N_CMP; i++) begin
                    if (w_idx == 5'(4 + 2*i)) w_rdata = r_cmp[i][31:0];
                    if (w_idx == 5'(5 + 2*i)) w_rdata = 32'(r_cmp[i][CNT_W-1:32]);
                end
            end
        endcase
    end

    // The shadow grabs the upper half in the same edge as the LO read so a
    // following HI read pairs with it even across a 32-bit carry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dout      <= '0;
            r_hi_shadow <= '0;
        end else if (w_rd) begin
            r_dout <= w_rdata;
            if (w_idx == 5'd0) r_hi_shadow <= r_count[CNT_W-1:32];
        end
    end

    assign bus.dout = r_dout;
    assign bus.irq  = r_irq;
endmodule
